// File: rtl/ama_riscv_simd_mac.sv
// ama_riscv_simd_mac: pipelined RV M-extension multiply and packed signed/unsigned dot-product-accumulate with valid/ready flow control
module ama_riscv_simd_mac #(
  parameter int XLEN = 32,
  parameter int STAGES = 2,
  parameter bit SAT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            sat,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] p,
  output logic            busy
);
  localparam int W = XLEN + 2;
  localparam int PW = 2 * XLEN + 2;
  logic signed [XLEN:0] ma, mb;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0] dsum;
  logic ovf, uns;
  logic [XLEN-1:0] dres, res;
  logic stall;
  logic [STAGES-1:0] v;
  logic [XLEN-1:0] d [STAGES];
  always_comb begin
    ma = {(op == 3'd1 || op == 3'd2) ? a[XLEN-1] : 1'b0, a};
    mb = {op == 3'd1 ? b[XLEN-1] : 1'b0, b};
    prod = PW'(ma) * PW'(mb);
    uns = op == 3'd7;
    dsum = W'($signed(c));
    for (int i = 0; i < XLEN / 16; i++)
      if (op == 3'd4)
        dsum = dsum + W'($signed(a[i*16 +: 16])) * W'($signed(b[i*16 +: 16]));
    for (int i = 0; i < XLEN / 8; i++)
      if (op == 3'd5 || uns)
        dsum = dsum + W'($signed({~uns & a[i*8+7], a[i*8 +: 8]})) * W'($signed({~uns & b[i*8+7], b[i*8 +: 8]}));
    for (int i = 0; i < XLEN / 4; i++)
      if (op == 3'd6)
        dsum = dsum + W'($signed(a[i*4 +: 4])) * W'($signed(b[i*4 +: 4]));
    ovf = !(&dsum[W-1:XLEN-1] || ~|dsum[W-1:XLEN-1]);
    dres = (SAT_EN && sat && ovf) ? {dsum[W-1], {(XLEN-1){~dsum[W-1]}}} : dsum[XLEN-1:0];
    res = op == 3'd0 ? prod[XLEN-1:0] : op[2] ? dres : prod[2*XLEN-1:XLEN];
  end
  assign stall = v[STAGES-1] && !out_ready;
  assign in_ready = !stall;
  assign out_valid = v[STAGES-1];
  assign p = d[STAGES-1];
  assign busy = |v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (!stall) begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= res;
      for (int k = 1; k < STAGES; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) d[k] <= d[k-1];
      end
    end
  end
endmodule

// File: tb/tb_ama_riscv_simd_mac.sv
// tb_ama_riscv_simd_mac: scoreboard bench for the 32-bit/2-stage and 64-bit/3-stage configurations
module tb_ama_riscv_simd_mac;
  localparam int S32 = 2;
  localparam int S64 = 3;
  localparam longint MX = 64'sh7FFFFFFF;
  localparam longint MN = -64'sh80000000;
  logic clk = 1'b0;
  logic rst_n = 1'b1, rst64_n = 1'b1;
  logic fl32 = 1'b0, iv32 = 1'b0, ir32, sat32 = 1'b0, ov32, or32 = 1'b1, bz32;
  logic [2:0] op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, c32 = '0, p32, nx32;
  logic fl64 = 1'b0, iv64 = 1'b0, ir64, sat64 = 1'b0, ov64, or64 = 1'b1, bz64;
  logic [2:0] op64 = '0;
  logic [63:0] a64 = '0, b64 = '0, c64 = '0, p64, nx64;
  logic [31:0] q32 [$];
  logic [63:0] q64 [$];
  int checks = 0, failures = 0, n32 = 0;
  bit acc32, acc64;
  always #5 clk = ~clk;
  ama_riscv_simd_mac #(.XLEN(32), .STAGES(S32), .SAT_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(fl32), .in_valid(iv32), .in_ready(ir32), .op(op32), .sat(sat32),
    .a(a32), .b(b32), .c(c32), .out_valid(ov32), .out_ready(or32), .p(p32), .busy(bz32));
  ama_riscv_simd_mac #(.XLEN(64), .STAGES(S64), .SAT_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst64_n), .flush(fl64), .in_valid(iv64), .in_ready(ir64), .op(op64), .sat(sat64),
    .a(a64), .b(b64), .c(c64), .out_valid(ov64), .out_ready(or64), .p(p64), .busy(bz64));
  function automatic logic [31:0] m32(input logic [2:0] o, input logic s, input logic [31:0] x, y, z);
    longint sx, sy, t, lx, ly;
    longint unsigned u;
    int n;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin t = sx * sy; return t[31:0]; end
      3'd1: begin t = sx * sy; return t[63:32]; end
      3'd2: begin t = sx * longint'({32'b0, y}); return t[63:32]; end
      3'd3: begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      default: begin
        n = o == 3'd4 ? 16 : o == 3'd6 ? 4 : 8;
        t = longint'($signed(z));
        for (int i = 0; i < 32 / n; i++) begin
          lx = longint'((x >> (i * n)) & ((32'd1 << n) - 32'd1));
          ly = longint'((y >> (i * n)) & ((32'd1 << n) - 32'd1));
          if (o != 3'd7) begin
            if (lx >= (longint'(1) << (n - 1))) lx -= longint'(1) << n;
            if (ly >= (longint'(1) << (n - 1))) ly -= longint'(1) << n;
          end
          t += lx * ly;
        end
        if (s) t = t > MX ? MX : t < MN ? MN : t;
        return t[31:0];
      end
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    acc32 = 1'b0;
    acc64 = 1'b0;
    if (!rst_n || fl32) q32.delete();
    else begin
      if (ov32 && or32) begin
        n32++;
        e = 'x;
        if (q32.size() > 0) e = 64'(q32.pop_front());
        chk("u32 result", 64'(p32), e);
      end
      if (iv32 && ir32) begin q32.push_back(nx32); acc32 = 1'b1; end
    end
    if (!rst64_n || fl64) q64.delete();
    else begin
      if (ov64 && or64) begin
        e = 'x;
        if (q64.size() > 0) e = q64.pop_front();
        chk("u64 result", p64, e);
      end
      if (iv64 && ir64) begin q64.push_back(nx64); acc64 = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic s32(input logic [2:0] o, input logic s, input logic [31:0] x, y, z, e, input string tag);
    int lat;
    op32 = o; sat32 = s; a32 = x; b32 = y; c32 = z; nx32 = e; iv32 = 1'b1;
    tick();
    chk({tag, " accept"}, 64'(acc32), 64'd1);
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 8) begin tick(); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(S32 - 1));
    tick();
  endtask
  task automatic s64(input logic [2:0] o, input logic s, input logic [63:0] x, y, z, e, input string tag);
    int lat;
    op64 = o; sat64 = s; a64 = x; b64 = y; c64 = z; nx64 = e; iv64 = 1'b1;
    tick();
    chk({tag, " accept"}, 64'(acc64), 64'd1);
    iv64 = 1'b0;
    lat = 0;
    while (!ov64 && lat < 8) begin tick(); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(S64 - 1));
    tick();
  endtask
  task automatic d32(input logic [2:0] o, input logic s, input logic [31:0] x, y, z);
    op32 = o; sat32 = s; a32 = x; b32 = y; c32 = z; nx32 = m32(o, s, x, y, z); iv32 = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] hold;
    logic any;
    int g, n0;
    #1 rst_n = 1'b0; rst64_n = 1'b0;
    #2;
    chk("reset out_valid", 64'(ov32), 64'd0);
    chk("reset busy", 64'(bz32), 64'd0);
    chk("reset p", 64'(p32), 64'd0);
    chk("reset in_ready", 64'(ir32), 64'd1);
    chk("reset64 p", p64, 64'd0);
    tick();
    tick();
    rst_n = 1'b1; rst64_n = 1'b1;
    s32(3'd0, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h0, 32'hFFFFFFFD, "MUL");
    s32(3'd1, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h0, 32'hFFFFFFFF, "MULH");
    s32(3'd2, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h0, 32'hFFFFFFFF, "MULHSU");
    s32(3'd3, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h0, 32'h00000002, "MULHU");
    s32(3'd0, 1'b1, 32'hFFFFFFFF, 32'h3, 32'h0, 32'hFFFFFFFD, "MUL sat");
    s32(3'd5, 1'b0, 32'h80808080, 32'h80808080, 32'h0, 32'h00010000, "DOT8");
    s32(3'd5, 1'b1, 32'h80808080, 32'h80808080, 32'h0, 32'h00010000, "DOT8 sat");
    s32(3'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0003F804, "DOT8U");
    s32(3'd4, 1'b0, 32'h80008000, 32'h80008000, 32'h0, 32'h80000000, "DOT16 wrap");
    s32(3'd4, 1'b1, 32'h80008000, 32'h80008000, 32'h0, 32'h7FFFFFFF, "DOT16 sat");
    s32(3'd4, 1'b0, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 32'h00010000, "DOT16 neg wrap");
    s32(3'd4, 1'b1, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 32'h80000000, "DOT16 neg sat");
    s32(3'd6, 1'b0, 32'h77777777, 32'h88888888, 32'h000001C0, 32'h00000000, "DOT4");
    n0 = n32;
    d32(3'd5, 1'b0, 32'h01FF7F80, 32'h02037F80, 32'h1);
    tick();
    d32(3'd5, 1'b0, 32'hF00F1234, 32'h7F80FF01, 32'h2);
    tick();
    d32(3'd5, 1'b0, 32'h11223344, 32'h55667788, 32'h3);
    or32 = 1'b0;
    hold = p32;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall in_ready", 64'(ir32), 64'd0);
      chk("stall out_valid", 64'(ov32), 64'd1);
      chk("stall p stable", 64'(p32), 64'(hold));
      tick();
      chk("stall no accept", 64'(acc32), 64'd0);
    end
    or32 = 1'b1;
    tick();
    d32(3'd5, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h4);
    tick();
    iv32 = 1'b0;
    g = 0;
    while (q32.size() > 0 && g < 10) begin tick(); g++; end
    chk("backpressure output count", 64'(n32 - n0), 64'd4);
    for (int i = 0; i < 24; i++) begin
      d32(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      g = 0;
      do begin or32 = 1'($urandom_range(0, 1)); tick(); g++; end while (!acc32 && g < 20);
      chk("random accept", 64'(acc32), 64'd1);
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    g = 0;
    while (q32.size() > 0 && g < 20) begin tick(); g++; end
    chk("random drain", 64'(q32.size()), 64'd0);
    s64(3'd4, 1'b0, 64'h7FFF7FFF7FFF7FFF, 64'h7FFF7FFF7FFF7FFF, 64'h0, 64'h00000000FFFC0004, "DOT16x64");
    s64(3'd3, 1'b0, '1, '1, 64'h0, 64'hFFFFFFFFFFFFFFFE, "MULHUx64");
    s64(3'd0, 1'b0, '1, 64'h3, 64'h0, 64'hFFFFFFFFFFFFFFFD, "MULx64");
    s64(3'd1, 1'b0, '1, 64'h3, 64'h0, 64'hFFFFFFFFFFFFFFFF, "MULHx64");
    s64(3'd5, 1'b0, 64'h8080808080808080, 64'h8080808080808080, 64'h0, 64'h0000000000020000, "DOT8x64");
    op64 = 3'd0; a64 = 64'h5; b64 = 64'h7; nx64 = 64'd35; iv64 = 1'b1;
    tick();
    a64 = 64'h9; nx64 = 64'd63;
    tick();
    fl64 = 1'b1;
    a64 = 64'hB; nx64 = 64'd77;
    tick();
    fl64 = 1'b0;
    iv64 = 1'b0;
    chk("flush busy", 64'(bz64), 64'd0);
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin any |= ov64; tick(); end
    chk("flush no output", 64'(any), 64'd0);
    s64(3'd6, 1'b0, 64'h1111111111111111, 64'hFFFFFFFFFFFFFFFF, 64'h20, 64'h0000000000000010, "post-flush DOT4x64");
    op64 = 3'd0; a64 = 64'h6; b64 = 64'h7; nx64 = 64'd42; iv64 = 1'b1;
    tick();
    a64 = 64'h8;
    nx64 = 64'd56;
    tick();
    tick();
    iv64 = 1'b0;
    chk("pre-reset out_valid", 64'(ov64), 64'd1);
    chk("pre-reset p", p64, 64'd42);
    #2 rst64_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(ov64), 64'd0);
    chk("async reset busy", 64'(bz64), 64'd0);
    chk("async reset p", p64, 64'd0);
    chk("async reset in_ready", 64'(ir64), 64'd1);
    tick();
    rst64_n = 1'b1;
    s64(3'd4, 1'b1, 64'h8000800080008000, 64'h8000800080008000, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, "post-reset DOT16x64 sat");
    chk("final u32 queue", 64'(q32.size()), 64'd0);
    chk("final u64 queue", 64'(q64.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
